s3g_tx_arb: RTL and testbench

S3G_TX_ARB -- requirements
Module: s3g_tx_arb

---
 rtl/s3g_pkg.sv | 18 +
 rtl/s3g_rr_arb.sv | 25 ++
 rtl/s3g_tx_arb.sv | 178 +++++++++++++++++
 tb/tb_s3g_tx_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared types and constants for the s3g transmit arbiter.
package s3g_pkg;
  localparam int unsigned S3G_MAX_PAYLOAD   = 15;
  localparam int unsigned S3G_PAYLOAD_BYTES = 16;
  localparam int unsigned S3G_BUF_W         = 8 * S3G_PAYLOAD_BYTES;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } s3g_state_e;

  // Search origin for the next arbitration once requester idx has been picked.
  function automatic int unsigned s3g_next_ptr(input int unsigned idx, input int unsigned nreq);
    return (idx + 1) % nreq;
  endfunction
endpackage

// File: rtl/s3g_rr_arb.sv
// Round-robin selector: first set request at or after ptr, wrapping, as a one-hot vector.
module s3g_rr_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel
);

  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      logic [PW-1:0] idx;
      idx = PW'((32'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s3g_tx_arb.sv
// Arbitrates NREQ packet requesters onto one transmitter, one packet outstanding at a time.
// Define S3G_TX_ARB_WDOG_EN to abort a stuck transmission after WDOG_CYCLES clocks.
module s3g_tx_arb
  import s3g_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_len,
  input  logic [S3G_BUF_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]           req_ack,
  output logic [NREQ-1:0]           req_sent,
  output logic [NREQ-1:0]           req_err,
  output logic [NREQ-1:0]           grant,
  output logic                      tx_packet_wr,
  output logic [7:0]                tx_payload_len,
  output logic [S3G_BUF_W-1:0]      tx_buf,
  input  logic                      tx_busy
);

  localparam int unsigned PW = $clog2(NREQ);

  s3g_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [NREQ-1:0]      sent_q, sent_d;
  logic [NREQ-1:0]      err_q, err_d;
  logic                 wr_q, wr_d;
  logic [7:0]           len_q, len_d;
  logic [S3G_BUF_W-1:0] buf_q, buf_d;

  logic [NREQ-1:0]      elig, sel;
  logic [7:0]           sel_len;
  logic [S3G_BUF_W-1:0] sel_data;
  logic [PW-1:0]        sel_ptr;
  logic                 wdog_hit;

  // A request acked last cycle is still visible on req_valid but already consumed.
  assign elig = req_valid & ~ack_q;

  s3g_rr_arb #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_rr_arb (
    .req(elig),
    .ptr(ptr_q),
    .sel(sel)
  );

  always_comb begin
    sel_len  = '0;
    sel_data = '0;
    sel_ptr  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_len  = req_len[8*i +: 8];
        sel_data = req_data[S3G_BUF_W*i +: S3G_BUF_W];
        sel_ptr  = PW'(s3g_next_ptr(i, NREQ));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    len_d   = len_q;
    buf_d   = buf_q;
    ack_d   = '0;
    sent_d  = '0;
    err_d   = '0;
    wr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_busy && |sel) begin
          ptr_d = sel_ptr;
          ack_d = sel;
          if (sel_len > 8'(S3G_MAX_PAYLOAD)) begin
            err_d = sel;
          end else begin
            len_d   = sel_len;
            buf_d   = sel_data;
            grant_d = sel;
            wr_d    = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWaitBusy;
      StWaitBusy: begin
        if (wdog_hit) begin
          err_d   = grant_q;
          grant_d = '0;
          state_d = StIdle;
        end else if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (!tx_busy) begin
          sent_d  = grant_q;
          grant_d = '0;
          state_d = StIdle;
        end else if (wdog_hit) begin
          err_d   = grant_q;
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      sent_q  <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end

`ifdef S3G_TX_ARB_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_q, wdog_d;

  assign wdog_hit = (wdog_q == WW'(WDOG_CYCLES - 1));

  // Counts every cycle spent waiting on the transmitter; restarts on each new packet.
  always_comb begin
    wdog_d = '0;
    if ((state_q == StWaitBusy || state_q == StWaitDone) &&
        (state_d == StWaitBusy || state_d == StWaitDone)) begin
      wdog_d = wdog_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign req_ack        = ack_q;
  assign req_sent       = sent_q;
  assign req_err        = err_q;
  assign grant          = grant_q;
  assign tx_packet_wr   = wr_q;
  assign tx_payload_len = len_q;
  assign tx_buf         = buf_q;

endmodule

// File: tb/tb_s3g_tx_arb.sv
// Directed bench for s3g_tx_arb: cycle model comparison plus literal scenario checks.
module tb_s3g_tx_arb;
  localparam int unsigned NREQ = 3;
  localparam int unsigned WDOG = 8;
`ifdef S3G_TX_ARB_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
  localparam int S1_BUSY = 5;
`else
  localparam bit WDOG_ON = 1'b0;
  localparam int S1_BUSY = 20;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_len;
  logic [128*NREQ-1:0]  req_data;
  logic [NREQ-1:0]      req_ack, req_sent, req_err, grant;
  logic                 tx_packet_wr;
  logic [7:0]           tx_payload_len;
  logic [127:0]         tx_buf;
  logic                 tx_busy;

  s3g_tx_arb #(
    .NREQ       (NREQ),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_len       (req_len),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .req_sent      (req_sent),
    .req_err       (req_err),
    .grant         (grant),
    .tx_packet_wr  (tx_packet_wr),
    .tx_payload_len(tx_payload_len),
    .tx_buf        (tx_buf),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_phase;  // 0 idle, 1 strobe, 2 await busy rise, 3 await busy fall
  int              m_last, m_owner, m_wait;
  logic [NREQ-1:0] e_ack, e_err, e_sent, e_grant;
  logic            e_wr;
  logic [7:0]      e_len;
  logic [127:0]    e_buf;

  task automatic model_reset();
    m_phase = 0; m_last = NREQ - 1; m_owner = 0; m_wait = 0;
    e_ack = '0; e_err = '0; e_sent = '0; e_grant = '0;
    e_wr = 1'b0; e_len = '0; e_buf = '0;
  endtask

  task automatic model_done(input bit ok);
    if (ok) e_sent[m_owner] = 1'b1;
    else    e_err[m_owner]  = 1'b1;
    e_grant = '0;
    m_phase = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] consumed;
    int pick;
    consumed = e_ack;
    e_ack = '0; e_err = '0; e_sent = '0; e_wr = 1'b0;
    case (m_phase)
      0: if (!tx_busy) begin
        pick = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (pick < 0 && req_valid[c] && !consumed[c]) pick = c;
        end
        if (pick >= 0) begin
          m_last = pick;
          e_ack[pick] = 1'b1;
          if (req_len[8*pick +: 8] > 8'd15) begin
            e_err[pick] = 1'b1;
          end else begin
            e_wr = 1'b1;
            e_len = req_len[8*pick +: 8];
            e_buf = req_data[128*pick +: 128];
            e_grant = '0;
            e_grant[pick] = 1'b1;
            m_owner = pick;
            m_phase = 1;
          end
        end
      end
      1: begin m_phase = 2; m_wait = 0; end
      default: begin
        m_wait++;
        if (m_phase == 3 && !tx_busy)                 model_done(1'b1);
        else if (WDOG_ON && m_wait == int'(WDOG))     model_done(1'b0);
        else if (m_phase == 2 && tx_busy)             m_phase = 3;
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_ack",   req_ack,        e_ack);
      check("cyc_sent",  req_sent,       e_sent);
      check("cyc_err",   req_err,        e_err);
      check("cyc_grant", grant,          e_grant);
      check("cyc_wr",    tx_packet_wr,   e_wr);
      check("cyc_len",   tx_payload_len, e_len);
      check("cyc_buf",   tx_buf,         e_buf);
    end
  end

  // ---------------- stimulus ----------------
  int pend [NREQ];
  bit tx_auto;
  int busy_len, busy_cnt;
  bit start_pend;
  int n_strobe, n_sent, n_errp;
  int strobe_q[$];

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [127:0] mkdata(input int i);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * (i + 1) + k);
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] && pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) req_valid[i] = 1'b0;
      end
    end
    if (tx_auto) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (start_pend) begin
        tx_busy = 1'b1; busy_cnt = busy_len; start_pend = 1'b0;
      end
      if (tx_packet_wr) start_pend = 1'b1;
    end
    if (tx_packet_wr) begin n_strobe++; strobe_q.push_back(oh_idx(grant)); end
    if (|req_sent) n_sent++;
    if (|req_err)  n_errp++;
  endtask

  task automatic post(input int i, input logic [7:0] len, input logic [127:0] data,
                      input int n);
    req_len[8*i +: 8]      = len;
    req_data[128*i +: 128] = data;
    pend[i]                = n;
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_until_quiet(input string name, input int limit);
    int n;
    n = 0;
    while (!(pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && grant == '0) && n < limit) begin
      tick(); n++;
    end
    check({name, "_quiet"}, 128'(n < limit), 128'(1));
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin tick(); n++; end while (!(|req_sent) && !(|req_err) && n < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n, base_s, base_e, base_w;
    rst_n = 1'b1; req_valid = '0; req_len = '0; req_data = '0; tx_busy = 1'b0;
    tx_auto = 1'b1; busy_len = 20; busy_cnt = 0; start_pend = 1'b0;
    n_strobe = 0; n_sent = 0; n_errp = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    #1 rst_n = 1'b0;
    tick();
    check("rst_grant", grant, 0);
    check("rst_wr", tx_packet_wr, 0);
    check("rst_buf", tx_buf, 0);
    check("rst_len", tx_payload_len, 0);
    tick(); #2 rst_n = 1'b1;
    tick();

    // Single requester 1, len 5, ramp payload
    busy_len = S1_BUSY;
    post(1, 8'd5, 128'h0F0E0D0C0B0A09080706050403020100, 1);
    tick();
    check("s1_wr", tx_packet_wr, 1);
    check("s1_len", tx_payload_len, 5);
    check("s1_buf", tx_buf, 128'h0F0E0D0C0B0A09080706050403020100);
    check("s1_ack", req_ack, 3'b010);
    check("s1_grant", grant, 3'b010);
    wait_pulse(80, n);
    check("s1_sent_lat", n, S1_BUSY + 2);
    check("s1_sent", req_sent, 3'b010);
    check("s1_hold_buf", tx_buf, 128'h0F0E0D0C0B0A09080706050403020100);

    // Oversize from requester 2 is rejected; requester 0 served right after
    post(2, 8'd16, mkdata(2), 1);
    post(0, 8'd3, mkdata(0), 1);
    base_w = n_strobe;
    tick();
    check("s3_ack", req_ack, 3'b100);
    check("s3_err", req_err, 3'b100);
    check("s3_wr", tx_packet_wr, 0);
    tick();
    check("s3_next_wr", tx_packet_wr, 1);
    check("s3_next_grant", grant, 3'b001);
    wait_until_quiet("s3", 80);
    check("s3_strobes", n_strobe - base_w, 1);

    // All three continuously requesting after reset
    tick(); #2 rst_n = 1'b0;
    tick(); #2 rst_n = 1'b1;
    busy_len = 3;
    strobe_q.delete();
    post(0, 8'd1, mkdata(0), 2);
    post(1, 8'd2, mkdata(1), 2);
    post(2, 8'd15, mkdata(2), 2);
    wait_until_quiet("s2", 300);
    check("s2_count", strobe_q.size(), 6);
    for (int j = 0; j < 6; j++) check("s2_order", strobe_q[j], j % 3);

    // Busy held high while idle blocks arbitration
    tick();
    tx_auto = 1'b0; tx_busy = 1'b1;
    base_w = n_strobe;
    post(0, 8'd4, mkdata(0), 1);
    repeat (6) tick();
    check("s4_no_wr", n_strobe - base_w, 0);
    tx_busy = 1'b0;
    tick();
    check("s4_wr", tx_packet_wr, 1);
    tick(); tx_busy = 1'b1;
    tick(); tick(); tx_busy = 1'b0;
    wait_pulse(20, n);
    check("s4_sent", req_sent, 3'b001);

    // Reset while waiting for the transmitter to finish
    tx_auto = 1'b1; busy_len = 20;
    post(1, 8'd7, mkdata(1), 1);
    n = 0;
    do begin tick(); n++; end while (!tx_packet_wr && n < 20);
    check("s6_started", tx_packet_wr, 1);
    repeat (5) tick();
    base_s = n_sent; base_e = n_errp;
    #2 rst_n = 1'b0;
    tx_auto = 1'b0; tx_busy = 1'b0; busy_cnt = 0; start_pend = 1'b0;
    #1;
    check("s6_rst_grant", grant, 0);
    check("s6_rst_buf", tx_buf, 0);
    check("s6_rst_len", tx_payload_len, 0);
    check("s6_rst_pulses", {req_ack, req_sent, req_err, tx_packet_wr}, 0);
    tick(); tick(); #2 rst_n = 1'b1;
    tx_auto = 1'b1; busy_len = 3;
    post(1, 8'd9, mkdata(1), 1);
    post(0, 8'd8, mkdata(0), 1);
    tick();
    check("s6_first_grant", grant, 3'b001);
    check("s6_no_pulses", (n_sent - base_s) + (n_errp - base_e), 0);
    wait_until_quiet("s6", 80);

`ifdef S3G_TX_ARB_WDOG_EN
    // Transmitter never goes busy: watchdog aborts the grant
    tick();
    tx_auto = 1'b0; tx_busy = 1'b0;
    post(0, 8'd2, mkdata(0), 1);
    tick();
    check("s5_wr", tx_packet_wr, 1);
    wait_pulse(30, n);
    check("s5_err_lat", n, 9);
    check("s5_err", req_err, 3'b001);
    check("s5_sent", req_sent, 0);
    check("s5_grant", grant, 0);
    tx_auto = 1'b1; busy_len = 3;
    post(2, 8'd1, mkdata(2), 1);
    tick();
    check("s5_idle_again", grant, 3'b100);
    wait_until_quiet("s5", 40);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
